// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - per-channel PWM LED driver with stepped afterglow decay
// Optional quadratic brightness curve: define LED_FADE_PWM_GAMMA_EN.
module led_fade_pwm #(
    parameter int CH         = 4,
    parameter int PWM_BITS   = 8,
    parameter int DECAY_W    = 16,
    parameter int DECAY_STEP = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [CH-1:0] LED_IN,
    output logic [CH-1:0] LED_OUT
);

    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [DECAY_W-1:0]  DEC_ONE  = DECAY_W'(1);

    logic [CH-1:0]       in_q, in_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DECAY_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic [PWM_BITS-1:0] level_q [CH];
    logic [PWM_BITS-1:0] level_d [CH];
    logic [PWM_BITS-1:0] lvl_eff [CH];
    logic [CH-1:0]       led_out_q, led_out_d;
    logic                tick;

    assign tick    = &dec_cnt_q;
    assign LED_OUT = led_out_q;

    always_comb begin
        in_d      = LED_IN;
        pwm_cnt_d = pwm_cnt_q + PWM_ONE;
        dec_cnt_d = dec_cnt_q + DEC_ONE;
        for (int i = 0; i < CH; i++) begin
            // A commanded-on channel always snaps back to full, even on a decay tick.
            if (in_q[i]) begin
                level_d[i] = MAX;
            end else if (tick) begin
                level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
            end else begin
                level_d[i] = level_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
`ifdef LED_FADE_PWM_GAMMA_EN
            lvl_eff[i] = PWM_BITS'(({{PWM_BITS{1'b0}}, level_q[i]} *
                                    {{PWM_BITS{1'b0}}, level_q[i]}) >> PWM_BITS);
`else
            lvl_eff[i] = level_q[i];
`endif
        end
    end

    always_comb begin
        led_out_d = '0;
        for (int i = 0; i < CH; i++) begin
            led_out_d[i] = (pwm_cnt_q < lvl_eff[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            in_q      <= '0;
            pwm_cnt_q <= '0;
            dec_cnt_q <= '0;
            led_out_q <= '0;
            for (int i = 0; i < CH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            in_q      <= in_d;
            pwm_cnt_q <= pwm_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            led_out_q <= led_out_d;
            for (int i = 0; i < CH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// tb/tb_led_fade_pwm.sv - directed bench for led_fade_pwm (default and small-parameter instances)
module tb_led_fade_pwm;

`ifdef LED_FADE_PWM_GAMMA_EN
    localparam bit GAMMA = 1'b1;
`else
    localparam bit GAMMA = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       rst_d, rst_s;
    logic [3:0] in_d, out_d, in_s, out_s;
    int         checks = 0;
    int         passes = 0;
    int         k      = 0;
    int         ones, hi, ones0, ones1;
    int         exp0 [6] = '{15, 11, 7, 3, 0, 0};
    int         exp1 [6] = '{15, 11, 15, 11, 7, 3};

    always #5 CLK = ~CLK;

    led_fade_pwm u_d (
        .CLK     (CLK),
        .RST     (rst_d),
        .LED_IN  (in_d),
        .LED_OUT (out_d)
    );

    led_fade_pwm #(
        .CH         (4),
        .PWM_BITS   (4),
        .DECAY_W    (4),
        .DECAY_STEP (4)
    ) u_s (
        .CLK     (CLK),
        .RST     (rst_s),
        .LED_IN  (in_s),
        .LED_OUT (out_s)
    );

    function automatic int eff(input int lvl, input int bits);
        return GAMMA ? ((lvl * lvl) >> bits) : lvl;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        k++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    initial begin
        rst_d = 1'b0;
        rst_s = 1'b0;
        in_d  = 4'hF;
        in_s  = 4'h0;
        #1;

        // Reset holds outputs low even with every channel commanded on
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_hold", 32'(out_d), 0);
        end
        rst_d = 1'b1;
        k = 0;
        step(); chk("latency_e1", 32'(out_d), 0);
        step(); chk("latency_e2", 32'(out_d), 0);
        step(); chk("latency_e3", 32'(out_d), 32'hF);

        // Steady single channel at full brightness, default parameters
        rst_d = 1'b0;
        in_d  = 4'b0001;
        step();
        step();
        rst_d = 1'b1;
        k = 0;
        step(); step(); step();
        ones = 0;
        hi   = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            ones += int'(out_d[0]);
            if (out_d[3:1] !== 3'b000) hi++;
        end
        chk("steady_duty", 32'(ones), 32'(eff(255, 8)));
        chk("steady_others_off", 32'(hi), 0);

        // Small instance: tick edges fall on k = 16, 32, 48, ...
        rst_s = 1'b1;
        k = 0;
        while (k < 14) step();
        in_s = 4'b0011;
        step();
        in_s = 4'b0000;
        while (k < 16) step();
        for (int j = 0; j < 6; j++) begin
            ones0 = 0;
            ones1 = 0;
            for (int i = 0; i < 16; i++) begin
                step();
                ones0 += int'(out_s[0]);
                ones1 += int'(out_s[1]);
                if (k == 46) in_s = 4'b0010;
                if (k == 47) in_s = 4'b0000;
            end
            chk($sformatf("decay_ch0_win%0d", j), 32'(ones0), 32'(eff(exp0[j], 4)));
            chk($sformatf("decay_ch1_win%0d", j), 32'(ones1), 32'(eff(exp1[j], 4)));
        end

        // Channel 2 fades to 7, then reset lands mid-fade
        while (k < 126) step();
        in_s = 4'b0100;
        step();
        in_s = 4'b0000;
        while (k < 162) step();
        chk("midfade_on", 32'(out_s[2]), 1);
        rst_s = 1'b0;
        step();
        chk("reset_midfade", 32'(out_s), 0);
        rst_s = 1'b1;
        k = 0;
        hi = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            if (out_s !== 4'b0000) hi++;
        end
        chk("no_residual_glow", 32'(hi), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream output stage for the LED chaser: takes the 4-bit one-hot LED pattern produced by the blink sequencer and drives the physical LEDs through per-channel PWM with a decaying afterglow. A lit LED shows full brightness. When its pattern bit drops, its brightness ramps down in fixed steps, so the sweep leaves a fading trail. The block sits between the pattern generator and the board LED pins.

## Interface
- `CH`, 4: number of LED channels.
- `PWM_BITS`, 8: brightness and PWM counter width. `MAX` = 2^PWM_BITS−1.
- `DECAY_W`, 16: decay prescaler width. One decay tick occurs every 2^DECAY_W cycles.
- `DECAY_STEP`, 16: brightness subtracted per decay tick. Must satisfy 1 ≤ `DECAY_STEP` ≤ `MAX`.
- `CLK`, in, 1: clock, 100 MHz.
- `RST`, in, 1: reset, synchronous, active-low. The clock is `CLK`.
- `LED_IN`, in, `CH`: pattern from the sequencer. Bit = 1 means the LED is commanded on.
- `LED_OUT`, out, `CH`: PWM-modulated LED drive, registered.

## Operation
- `in_q[CH-1:0]`: input register that samples `LED_IN` every cycle.
- `pwm_cnt[PWM_BITS-1:0]`: free-running counter, 0 → `MAX`, then wraps to 0. Shared by all channels.
- `dec_cnt[DECAY_W-1:0]`: free-running prescaler.
  - `tick` = (`dec_cnt` == all ones), combinational, high for 1 cycle.
  - `dec_cnt` wraps to 0 on the cycle after `tick`.
- `level[i][PWM_BITS-1:0]`: per-channel brightness register. Priority, highest first:
  - `in_q[i]`=1 → `level[i]` <= `MAX`. This wins even when `tick` is high in the same cycle.
  - else `tick`=1 → saturating subtract: `level[i]` <= (`level[i]` > `DECAY_STEP`) ? `level[i]`−`DECAY_STEP` : 0. The result never wraps.
  - else `level[i]` holds its value.
- `lvl_eff[i]`: combinational, equal to `level[i]` by default. See Configuration.
- `LED_OUT[i]` <= (`pwm_cnt` < `lvl_eff[i]`).
  - Duty = `lvl_eff`/2^PWM_BITS, so full brightness is `MAX`/2^PWM_BITS.
  - `lvl_eff`=0 gives a constant 0.
- All channels are independent. Several bits of `LED_IN` may be high at once.
- Reset (`RST`=0 at a rising edge):
  - `in_q`, `pwm_cnt`, `dec_cnt`, every `level`, and `LED_OUT` all go to 0.
  - Reset has priority over all other updates.
  - Reset asserted mid-fade clears levels immediately. There is no residual glow after release.

## Timing
- `LED_IN` change at edge N → `in_q` at N+1 → `level` at N+2 → `LED_OUT` at N+3. Total latency is 3 cycles.
- The decay tick affects `level` on the edge ending the tick cycle. `LED_OUT` reflects the new level one cycle later.
- `pwm_cnt` and `dec_cnt` both start at 0 on the first edge after `RST` release. They advance by 1 every cycle.
- Duty-cycle changes are not synchronised to the PWM period. A mid-period level change takes effect at the next compare.
- There is no handshake. `LED_IN` is treated as quasi-static level data from the same clock domain.

## Configuration
- Macro: `LED_FADE_PWM_GAMMA_EN`.
- Defined: `lvl_eff[i]` = (`level[i]` × `level[i]`) >> `PWM_BITS`. The product is 2·PWM_BITS wide and is truncated, giving a perceptual quadratic fade.
  - Computed combinationally, so latency is unchanged at 3 cycles.
- Undefined: `lvl_eff[i]` = `level[i]`, a linear fade.

## Test plan
- Reset: `RST`=0 for 10 cycles with `LED_IN`=4'hF → `LED_OUT`=0 throughout. After release, `LED_OUT[i]` first goes high 3 cycles after the first sampled edge.
- Steady on, default parameters, `LED_IN`=4'b0001 held:
  - `LED_OUT[0]` is high exactly 255 of every 256 cycles.
  - `LED_OUT[3:1]` stays 0.
- Decay, with `PWM_BITS`=4, `DECAY_W`=4, `DECAY_STEP`=4:
  - Pulse bit0 to 1, then 0 → `level` goes 15, 11, 7, 3, 0 on successive ticks, 16 cycles apart.
  - Measured duty per period is 15/16, 11/16, 7/16, 3/16, 0.
- Saturation: with `level`=3 and `DECAY_STEP`=4, a tick gives `level`=0. Further ticks keep 0 and never wrap to 15.
- Simultaneous events:
  - `in_q[1]`=1 in the same cycle as `tick` → `level[1]`=`MAX`.
  - Reset asserted while `level`=7 → `level`=0 and `LED_OUT`=0 on the next edge.
- Gamma (`LED_FADE_PWM_GAMMA_EN` defined, `PWM_BITS`=4):
  - `level` 15 → duty 14/16.
  - `level` 7 → duty 3/16.
  - `level` 3 → duty 0.
